// File: rtl/free_list.sv
// free_list: circular FIFO of unallocated physical register indices.
// Rename pops a fresh destination register from the head. Commit pushes the
// displaced physical register at the tail. A flush reclaims every speculative
// allocation in one cycle by pulling head back to just behind the tail.
//
// Handshake: alloc_ready is high whenever the FIFO is non-empty, and alloc_phy
// is valid in the same cycle. A grant happens at a rising edge when alloc_req
// and alloc_ready are both high and flush is low. Freed registers have no
// valid/ready handshake because free_en is always accepted. A write that
// arrives while the FIFO is full is dropped.
module free_list #(
  parameter int PRF_DEPTH = 64,
  parameter int ARF_DEPTH = 32,
  localparam int DEPTH    = PRF_DEPTH - ARF_DEPTH,
  localparam int PRF_IDX  = $clog2(PRF_DEPTH),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req,
  output logic               alloc_ready,
  output logic [PRF_IDX-1:0] alloc_phy,
  input  logic               free_en,
  input  logic [PRF_IDX-1:0] free_phy,
  input  logic               flush,
  output logic [PTR_W:0]     free_count
);

  // Each pointer holds PTR_W index bits plus one wrap bit at the MSB.
  // Because DEPTH is a power of two, adding 1 across the full width wraps the
  // index and toggles the wrap bit together.
  logic [PRF_IDX-1:0] mem_q [DEPTH];
  logic [PTR_W:0]     head_q, head_d;
  logic [PTR_W:0]     tail_q, tail_d;

  logic empty, full;
  logic do_alloc, do_free;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                 (head_q[PTR_W] != tail_q[PTR_W]);

  assign alloc_ready = !empty;
  assign alloc_phy   = mem_q[head_q[PTR_W-1:0]];
  assign free_count  = tail_q - head_q;

  // The free side is never blocked, except that a free into a full FIFO is
  // dropped. Allocation is suppressed during a flush because the head is
  // being rewritten anyway.
  assign do_free  = free_en && !full;
  assign do_alloc = alloc_req && !empty && !flush;

  // Next-state pointers. On a flush, any concurrent free is applied to the
  // tail first. The head then lands one full lap behind that new tail, so
  // every slot that was handed out since the last commit is back in the FIFO.
  // Dequeue never clears a slot.
  always_comb begin
    tail_d = tail_q;
    head_d = head_q;
    if (do_free) begin
      tail_d = tail_q + (PTR_W+1)'(1);
    end
    if (flush) begin
      head_d = {~tail_d[PTR_W], tail_d[PTR_W-1:0]};
    end else if (do_alloc) begin
      head_d = head_q + (PTR_W+1)'(1);
    end
  end

  // Pointer registers. Reset leaves the FIFO full, holding every register
  // that is not one of the architectural reset mappings.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= {1'b1, {PTR_W{1'b0}}};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Slot storage. Reset loads slot i with physical register ARF_DEPTH+i.
  // A commit writes the returned register at the tail slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PRF_IDX'(ARF_DEPTH + i);
      end
    end else if (do_free) begin
      mem_q[tail_q[PTR_W-1:0]] <= free_phy;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed scenario tests for free_list with hand-computed
// expectations, a FIFO reference queue for the steady-state scenario, and a
// per-cycle monitor for the count bound and the illegal-free rules.
module tb_free_list;

  localparam int DEPTH = 32;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_ready;
  logic [5:0] alloc_phy;
  logic       free_en;
  logic [5:0] free_phy;
  logic       flush;
  logic [5:0] free_count;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  logic [5:0] exp_q[$];

  free_list dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .alloc_ready (alloc_ready),
    .alloc_phy   (alloc_phy),
    .free_en     (free_en),
    .free_phy    (free_phy),
    .flush       (flush),
    .free_count  (free_count)
  );

  // Clock and reset: 10-unit period. Reset is held from time 0 until the
  // first edge has been taken by test_reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst       = 1'b1;
    alloc_req = 1'b0;
    free_en   = 1'b0;
    free_phy  = '0;
    flush     = 1'b0;
  end

  // Driver tasks. Inputs change 1 unit after a rising edge. Outputs are
  // sampled 1 unit after that edge, or 1 unit after a drive when the check
  // is for the current cycle.
  task automatic drive(input logic a, input logic fe, input logic [5:0] fp,
                       input logic fl, input logic r);
    alloc_req = a;
    free_en   = fe;
    free_phy  = fp;
    flush     = fl;
    rst       = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    free_en   = 1'b0;
    free_phy  = '0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic cycle(input logic a, input logic fe, input logic [5:0] fp,
                       input logic fl, input logic r);
    drive(a, fe, fp, fl, r);
    step();
  endtask

  // Monitor on the falling edge. It checks that the count never exceeds
  // DEPTH, that the bench never frees x0, and that it never frees into a
  // full FIFO.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!(free_count <= 6'(DEPTH))) begin
        failures++;
        $display("FAIL count_bound: free_count=%0d exceeds %0d", free_count, DEPTH);
      end
      if (free_en && !rst) begin
        checks++;
        if (free_phy == 6'd0) begin
          failures++;
          $display("FAIL free_x0: free_phy=%0d required nonzero", free_phy);
        end
        checks++;
        if (free_count == 6'(DEPTH)) begin
          failures++;
          $display("FAIL free_full: free_en with free_count=%0d", free_count);
        end
      end
    end
  end

  task automatic test_reset();
    cycle(0, 0, 6'd0, 0, 1);
    checks++;
    if (alloc_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", alloc_ready);
    end
    checks++;
    if (alloc_phy !== 6'd32) begin
      failures++; $display("FAIL reset_phy: got %0d want 32", alloc_phy);
    end
    checks++;
    if (free_count !== 6'd32) begin
      failures++; $display("FAIL reset_count: got %0d want 32", free_count);
    end
    checks++;
    if (dut.head_q !== 6'd0 || dut.tail_q !== 6'd32) begin
      failures++;
      $display("FAIL reset_ptrs: head=%0d tail=%0d want 0/32", dut.head_q, dut.tail_q);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_alloc_drain();
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 6'd0, 0, 0);
      #1;
      checks++;
      if (alloc_ready !== 1'b1 || alloc_phy !== 6'(32 + i)) begin
        failures++;
        $display("FAIL drain_phy[%0d]: ready=%b phy=%0d want 1/%0d", i, alloc_ready, alloc_phy, 32 + i);
      end
      step();
    end
    checks++;
    if (alloc_ready !== 1'b0 || free_count !== 6'd0) begin
      failures++;
      $display("FAIL drain_empty: ready=%b count=%0d want 0/0", alloc_ready, free_count);
    end
    cycle(1, 0, 6'd0, 0, 0);
    checks++;
    if (alloc_ready !== 1'b0 || free_count !== 6'd0 || dut.head_q !== 6'd32) begin
      failures++;
      $display("FAIL alloc_when_empty: ready=%b count=%0d head=%0d want 0/0/32", alloc_ready, free_count, dut.head_q);
    end
  endtask

  task automatic test_free_from_empty();
    drive(0, 1, 6'd5, 0, 0);
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      failures++; $display("FAIL free_no_bypass: ready=%b want 0", alloc_ready);
    end
    step();
    checks++;
    if (alloc_ready !== 1'b1 || alloc_phy !== 6'd5 || free_count !== 6'd1) begin
      failures++;
      $display("FAIL free_visible: ready=%b phy=%0d count=%0d want 1/5/1", alloc_ready, alloc_phy, free_count);
    end
    cycle(1, 0, 6'd0, 0, 0);
    checks++;
    if (free_count !== 6'd0) begin
      failures++; $display("FAIL free_realloc: count=%0d want 0", free_count);
    end
  endtask

  task automatic test_fifo_order();
    logic [5:0] want;
    exp_q = {};
    exp_q.push_back(6'd7);
    exp_q.push_back(6'd9);
    exp_q.push_back(6'd11);
    cycle(0, 1, 6'd7, 0, 0);
    cycle(0, 1, 6'd9, 0, 0);
    cycle(0, 1, 6'd11, 0, 0);
    checks++;
    if (free_count !== 6'd3) begin
      failures++; $display("FAIL order_count: count=%0d want 3", free_count);
    end
    for (int i = 0; i < 3; i++) begin
      want = exp_q.pop_front();
      drive(1, 0, 6'd0, 0, 0);
      #1;
      checks++;
      if (alloc_phy !== want) begin
        failures++; $display("FAIL order_phy[%0d]: got %0d want %0d", i, alloc_phy, want);
      end
      step();
    end
    checks++;
    if (alloc_ready !== 1'b0 || free_count !== 6'd0) begin
      failures++;
      $display("FAIL order_empty: ready=%b count=%0d want 0/0", alloc_ready, free_count);
    end
  endtask

  task automatic test_flush();
    logic [63:0] seen;
    logic [5:0]  want;
    int          dups;
    cycle(0, 0, 6'd0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 6'd0, 0, 0);
    cycle(0, 1, 6'd1, 0, 0);
    cycle(0, 1, 6'd2, 0, 0);
    checks++;
    if (free_count !== 6'd29) begin
      failures++; $display("FAIL flush_pre_count: count=%0d want 29", free_count);
    end
    cycle(1, 0, 6'd0, 1, 0);
    checks++;
    if (free_count !== 6'd32 || alloc_phy !== 6'd34) begin
      failures++;
      $display("FAIL flush_state: count=%0d phy=%0d want 32/34", free_count, alloc_phy);
    end
    // Retirement RAT after committing two writers that took 32 and 33 and
    // displaced 1 and 2.
    seen = '0;
    for (int r = 0; r < 32; r++) seen[r] = 1'b1;
    seen[1]  = 1'b0;
    seen[2]  = 1'b0;
    seen[32] = 1'b1;
    seen[33] = 1'b1;
    exp_q = {};
    for (int v = 34; v < 64; v++) exp_q.push_back(6'(v));
    exp_q.push_back(6'd1);
    exp_q.push_back(6'd2);
    dups = 0;
    for (int i = 0; i < 32; i++) begin
      want = exp_q.pop_front();
      drive(1, 0, 6'd0, 0, 0);
      #1;
      checks++;
      if (alloc_phy !== want) begin
        failures++; $display("FAIL flush_phy[%0d]: got %0d want %0d", i, alloc_phy, want);
      end
      if (seen[alloc_phy]) dups++;
      seen[alloc_phy] = 1'b1;
      step();
    end
    checks++;
    if (dups != 0 || seen !== {64{1'b1}}) begin
      failures++;
      $display("FAIL flush_conservation: dups=%0d seen=%h want 0/ffffffffffffffff", dups, seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] want;
    exp_q = {};
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 6'(10 + k), 0, 0);
      exp_q.push_back(6'(10 + k));
    end
    checks++;
    if (free_count !== 6'd10) begin
      failures++; $display("FAIL b2b_fill: count=%0d want 10", free_count);
    end
    for (int k = 0; k < 20; k++) begin
      want = exp_q.pop_front();
      exp_q.push_back(6'(40 + k));
      drive(1, 1, 6'(40 + k), 0, 0);
      #1;
      checks++;
      if (alloc_phy !== want) begin
        failures++; $display("FAIL b2b_phy[%0d]: got %0d want %0d", k, alloc_phy, want);
      end
      step();
      checks++;
      if (free_count !== 6'd10) begin
        failures++; $display("FAIL b2b_count[%0d]: got %0d want 10", k, free_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) cycle(1, 0, 6'd0, 0, 0);
    checks++;
    if (free_count !== 6'd3) begin
      failures++; $display("FAIL mid_pre_count: count=%0d want 3", free_count);
    end
    cycle(1, 1, 6'd9, 1, 1);
    checks++;
    if (free_count !== 6'd32 || alloc_phy !== 6'd32 || alloc_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: count=%0d phy=%0d ready=%b want 32/32/1", free_count, alloc_phy, alloc_ready);
    end
    checks++;
    if (dut.head_q !== 6'd0 || dut.tail_q !== 6'd32) begin
      failures++;
      $display("FAIL mid_reset_ptrs: head=%0d tail=%0d want 0/32", dut.head_q, dut.tail_q);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_drain();
    test_free_from_empty();
    test_fifo_order();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
